// File: rtl/scan_step_ctrl.sv
// Frequency-scan sequencer: walks the DDS tuning word through an equally spaced list,
// handshakes each point with the DDS loader, then settles and dwells with the acquisition switch open.
module scan_step_ctrl #(
    parameter int unsigned FTW_W = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLKA,
    input  logic             NSYSRESET,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [15:0]      cfg_data,
    input  logic             dds_done,
    output logic [FTW_W-1:0] ftw,
    output logic             dds_load,
    output logic             sw_acq,
    output logic             scanover,
    output logic             busy,
    output logic [CNT_W-1:0] point_idx
);

    localparam logic [2:0] ADDR_START_LO = 3'd0;
    localparam logic [2:0] ADDR_START_HI = 3'd1;
    localparam logic [2:0] ADDR_STEP_LO  = 3'd2;
    localparam logic [2:0] ADDR_STEP_HI  = 3'd3;
    localparam logic [2:0] ADDR_NPOINTS  = 3'd4;
    localparam logic [2:0] ADDR_SETTLE   = 3'd5;
    localparam logic [2:0] ADDR_DWELL    = 3'd6;
    localparam logic [2:0] ADDR_CTRL     = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_DDS = 3'd2,
        S_SETTLE   = 3'd3,
        S_ACQ      = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    // programmable registers
    logic [15:0]      r_start_lo;
    logic [15:0]      r_start_hi;
    logic [15:0]      r_step_lo;
    logic [15:0]      r_step_hi;
    logic [CNT_W-1:0] r_npoints;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] r_dwell;

    // working copies captured at start
    logic [FTW_W-1:0] r_step_l;
    logic [CNT_W-1:0] r_np_l;
    logic [CNT_W-1:0] r_settle_l;
    logic [CNT_W-1:0] r_dwell_l;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_idx;
    logic [FTW_W-1:0] r_ftw;
    logic             r_dds_load;
    logic             r_sw_acq;
    logic             r_scanover;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_idx_nxt;
    logic [FTW_W-1:0] w_ftw_nxt;
    logic             w_scanover_nxt;
    logic             w_latch;
    logic             w_ctrl_we;
    logic             w_start;
    logic             w_abort;
    logic [FTW_W-1:0] w_start_val;
    logic [FTW_W-1:0] w_step_val;
    logic [CNT_W-1:0] w_settle_eff;
    logic [CNT_W-1:0] w_dwell_eff;

    assign w_ctrl_we    = cfg_we && (cfg_addr == ADDR_CTRL);
    assign w_start      = w_ctrl_we && cfg_data[0];
    assign w_abort      = w_ctrl_we && cfg_data[1];
    assign w_start_val  = FTW_W'({r_start_hi, r_start_lo});
    assign w_step_val   = FTW_W'({r_step_hi, r_step_lo});
    assign w_settle_eff = (r_settle_l == '0) ? CNT_W'(1) : r_settle_l;
    assign w_dwell_eff  = (r_dwell_l == '0) ? CNT_W'(1) : r_dwell_l;

    // register file; ctrl is a strobe and is not stored
    always_ff @(posedge CLKA or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_start_lo <= '0;
            r_start_hi <= '0;
            r_step_lo  <= '0;
            r_step_hi  <= '0;
            r_npoints  <= '0;
            r_settle   <= '0;
            r_dwell    <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_START_LO: r_start_lo <= cfg_data;
                ADDR_START_HI: r_start_hi <= cfg_data;
                ADDR_STEP_LO:  r_step_lo  <= cfg_data;
                ADDR_STEP_HI:  r_step_hi  <= cfg_data;
                ADDR_NPOINTS:  r_npoints  <= CNT_W'(cfg_data);
                ADDR_SETTLE:   r_settle   <= CNT_W'(cfg_data);
                ADDR_DWELL:    r_dwell    <= CNT_W'(cfg_data);
                default: ;
            endcase
        end
    end

    // next-state and datapath updates; abort overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_ftw_nxt      = r_ftw;
        w_scanover_nxt = r_scanover;
        w_latch        = 1'b0;
        if (w_abort) begin
            w_state_nxt    = S_IDLE;
            w_scanover_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        if (r_npoints != '0) begin
                            w_latch        = 1'b1;
                            w_state_nxt    = S_LOAD;
                            w_ftw_nxt      = w_start_val;
                            w_idx_nxt      = '0;
                            w_scanover_nxt = 1'b0;
                        end else begin
                            w_scanover_nxt = 1'b1;
                        end
                    end
                end
                S_LOAD: w_state_nxt = S_WAIT_DDS;
                S_WAIT_DDS: begin
                    if (dds_done) begin
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = CNT_W'(w_settle_eff - CNT_W'(1));
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_ACQ;
                        w_cnt_nxt   = CNT_W'(w_dwell_eff - CNT_W'(1));
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
                    end
                end
                S_ACQ: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt - CNT_W'(1));
                    end
                end
                S_NEXT: begin
                    if (CNT_W'(r_idx + CNT_W'(1)) == r_np_l) begin
                        w_state_nxt    = S_DONE;
                        w_scanover_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_idx_nxt   = CNT_W'(r_idx + CNT_W'(1));
                        w_ftw_nxt   = FTW_W'(r_ftw + r_step_l);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // state, working copies and registered outputs decoded from the next state
    always_ff @(posedge CLKA or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_ftw      <= '0;
            r_scanover <= 1'b0;
            r_dds_load <= 1'b0;
            r_sw_acq   <= 1'b0;
            r_busy     <= 1'b0;
            r_step_l   <= '0;
            r_np_l     <= '0;
            r_settle_l <= '0;
            r_dwell_l  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_ftw      <= w_ftw_nxt;
            r_scanover <= w_scanover_nxt;
            r_dds_load <= (w_state_nxt == S_LOAD);
            r_sw_acq   <= (w_state_nxt == S_ACQ);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            if (w_latch) begin
                r_step_l   <= w_step_val;
                r_np_l     <= r_npoints;
                r_settle_l <= r_settle;
                r_dwell_l  <= r_dwell;
            end
        end
    end

    assign ftw       = r_ftw;
    assign dds_load  = r_dds_load;
    assign sw_acq    = r_sw_acq;
    assign scanover  = r_scanover;
    assign busy      = r_busy;
    assign point_idx = r_idx;

endmodule

// File: tb/tb_scan_step_ctrl.sv
// Directed + randomized bench for scan_step_ctrl; expected tuning words come from
// start + p*step arithmetic and expected timing from the settle/dwell rules.
module tb_scan_step_ctrl;

    localparam int unsigned FTW_W = 32;
    localparam int unsigned CNT_W = 16;

    logic             CLKA;
    logic             NSYSRESET;
    logic             cfg_we;
    logic [2:0]       cfg_addr;
    logic [15:0]      cfg_data;
    logic             dds_done;
    logic [FTW_W-1:0] ftw;
    logic             dds_load;
    logic             sw_acq;
    logic             scanover;
    logic             busy;
    logic [CNT_W-1:0] point_idx;

    scan_step_ctrl #(.FTW_W(FTW_W), .CNT_W(CNT_W)) dut (
        .CLKA      (CLKA),
        .NSYSRESET (NSYSRESET),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .dds_done  (dds_done),
        .ftw       (ftw),
        .dds_load  (dds_load),
        .sw_acq    (sw_acq),
        .scanover  (scanover),
        .busy      (busy),
        .point_idx (point_idx)
    );

    initial CLKA = 1'b0;
    always #5 CLKA = ~CLKA;

    int total = 0;
    int bad   = 0;
    int n_load = 0;

    always @(negedge CLKA) if (dds_load === 1'b1) n_load++;

    // reference model: programmed registers and the copies taken at start
    logic [15:0] m_reg [8];
    logic [31:0] l_start;
    logic [31:0] l_step;
    int          l_np;
    int          l_set;
    int          l_dw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLKA);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        step();
        cfg_we   = 1'b0;
        if (a != 3'd7) m_reg[a] = d;
    endtask

    function automatic logic [31:0] exp_ftw(input int p);
        logic [63:0] t;
        t = 64'(l_start) + 64'(p) * 64'(l_step);
        return t[31:0];
    endfunction

    task automatic program_regs(input logic [31:0] st, input logic [31:0] sp,
                                input int np, input int se, input int dw);
        wr(3'd0, st[15:0]);
        wr(3'd1, st[31:16]);
        wr(3'd2, sp[15:0]);
        wr(3'd3, sp[31:16]);
        wr(3'd4, 16'(np));
        wr(3'd5, 16'(se));
        wr(3'd6, 16'(dw));
    endtask

    task automatic start_scan();
        wr(3'd7, 16'h0001);
        if (m_reg[4] != 16'd0) begin
            l_start = {m_reg[1], m_reg[0]};
            l_step  = {m_reg[3], m_reg[2]};
            l_np    = int'(m_reg[4]);
            l_set   = int'(m_reg[5]);
            l_dw    = int'(m_reg[6]);
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_scanover", 64'(scanover), 64'd0);
        end else begin
            chk("np0_scanover", 64'(scanover), 64'd1);
            chk("np0_load", 64'(dds_load), 64'd0);
            chk("np0_busy", 64'(busy), 64'd0);
        end
    endtask

    // entered in the LOAD cycle of point p; leaves in the next LOAD cycle or the DONE cycle
    task automatic do_point(input int p, input int lat, input bit mid);
        int n;
        int s_eff;
        int d_eff;
        s_eff = (l_set == 0) ? 1 : l_set;
        d_eff = (l_dw == 0) ? 1 : l_dw;
        chk("load", 64'(dds_load), 64'd1);
        chk("ftw", 64'(ftw), 64'(exp_ftw(p)));
        chk("idx", 64'(point_idx), 64'(p));
        if (mid) begin
            wr(3'd2, 16'h0200);
            wr(3'd3, 16'h0000);
            wr(3'd7, 16'h0001);
        end
        repeat (lat) step();
        dds_done = 1'b1;
        step();
        dds_done = 1'b0;
        n = 0;
        while (sw_acq !== 1'b1 && n < 200) begin step(); n++; end
        chk("settle_len", 64'(n), 64'(s_eff));
        n = 0;
        while (sw_acq === 1'b1 && n < 200) begin step(); n++; end
        chk("dwell_len", 64'(n), 64'(d_eff));
        if (p == l_np - 1) begin
            chk("scanover_in_next", 64'(scanover), 64'd0);
            step();
            chk("scanover_done", 64'(scanover), 64'd1);
            chk("busy_done", 64'(busy), 64'd0);
        end else begin
            step();
        end
    endtask

    task automatic run_current(input int lat, input bit mid);
        int n0;
        n0 = n_load;
        start_scan();
        for (int p = 0; p < l_np; p++)
            do_point(p, (lat == 0) ? int'($urandom_range(1, 6)) : lat, mid && (p == 0));
        repeat (3) step();
        chk("n_load", 64'(n_load - n0), 64'(l_np));
    endtask

    initial begin
        int n;
        int n0;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
        NSYSRESET = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 3'd0;
        cfg_data  = 16'd0;
        dds_done  = 1'b0;
        step();
        step();
        chk("rst_ftw", 64'(ftw), 64'd0);
        chk("rst_load", 64'(dds_load), 64'd0);
        chk("rst_acq", 64'(sw_acq), 64'd0);
        chk("rst_scanover", 64'(scanover), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idx", 64'(point_idx), 64'd0);
        NSYSRESET = 1'b1;
        step();

        // start with npoints == 0
        n0 = n_load;
        start_scan();
        repeat (5) step();
        chk("np0_no_load", 64'(n_load - n0), 64'd0);

        // basic scan, loader latency 5
        program_regs(32'h0000_1000, 32'h0000_0100, 3, 4, 8);
        run_current(5, 1'b0);

        // tuning word wrap
        program_regs(32'hFFFF_FF80, 32'h0000_0100, 2, 1, 2);
        run_current(0, 1'b0);

        // zero settle/dwell, single point
        program_regs(32'h1234_5678, 32'h0000_0001, 1, 0, 0);
        run_current(0, 1'b0);

        // step rewritten and start issued mid-scan; next scan picks up the new step
        program_regs(32'h0001_0000, 32'h0000_0100, 3, 2, 3);
        run_current(0, 1'b1);
        run_current(0, 1'b0);

        // abort during ACQ of point 1, then restart
        program_regs(32'h0000_4000, 32'h0000_0040, 3, 2, 6);
        start_scan();
        do_point(0, 3, 1'b0);
        chk("abort_load", 64'(dds_load), 64'd1);
        repeat (3) step();
        dds_done = 1'b1;
        step();
        dds_done = 1'b0;
        n = 0;
        while (sw_acq !== 1'b1 && n < 200) begin step(); n++; end
        chk("abort_pre_acq", 64'(n), 64'd2);
        step();
        wr(3'd7, 16'h0002);
        chk("abort_acq", 64'(sw_acq), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_scanover", 64'(scanover), 64'd0);
        chk("abort_idx", 64'(point_idx), 64'd1);
        n0 = n_load;
        repeat (20) step();
        chk("abort_no_load", 64'(n_load - n0), 64'd0);
        run_current(0, 1'b0);

        // random scans
        for (int k = 0; k < 4; k++) begin
            program_regs($urandom, $urandom, int'($urandom_range(1, 4)),
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            run_current(0, 1'b0);
        end

        // reset while waiting on the loader
        program_regs(32'hABCD_0000, 32'h0000_0010, 3, 2, 2);
        start_scan();
        step();
        step();
        NSYSRESET = 1'b0;
        #1;
        chk("mrst_ftw", 64'(ftw), 64'd0);
        chk("mrst_load", 64'(dds_load), 64'd0);
        chk("mrst_acq", 64'(sw_acq), 64'd0);
        chk("mrst_scanover", 64'(scanover), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_idx", 64'(point_idx), 64'd0);
        for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
        n0 = n_load;
        step();
        NSYSRESET = 1'b1;
        step();
        dds_done = 1'b1;
        step();
        dds_done = 1'b0;
        repeat (10) step();
        chk("mrst_no_load", 64'(n_load - n0), 64'd0);
        chk("mrst_busy_after", 64'(busy), 64'd0);
        chk("mrst_acq_after", 64'(sw_acq), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scan_step_ctrl.md
# scan_step_ctrl

Sequencer for the frequency-scan datapath: steps the DDS tuning word through a programmed list of equally spaced points, issues one load request per point to the DDS serial loader, waits a settle interval, then opens the acquisition switch for a dwell interval. Sits between the DSP external-bus decode (register writes) and the DDS loader / acquisition switch logic inside the scan-frequency top level; raises `scanover` when the list is exhausted.

## Interface
Parameters:
- `FTW_W`, 32, DDS frequency tuning word width
- `CNT_W`, 16, width of point-count, settle and dwell registers

Ports:
- `CLKA`  in  1  system clock; all logic on rising edge
- `NSYSRESET`  in  1  asynchronous active-low reset
- `cfg_we`  in  1  one-cycle register write strobe (already decoded from `zcs2`/`xwe`/`xa`)
- `cfg_addr`  in  3  register select
- `cfg_data`  in  16  write data
- `dds_done`  in  1  one-cycle pulse from DDS loader: word shifted out and `ddsfqud` issued
- `ftw`  out  FTW_W  tuning word for current point, stable from `dds_load` until next `dds_load`
- `dds_load`  out  1  one-cycle load request to DDS loader
- `sw_acq`  out  1  acquisition switch enable
- `scanover`  out  1  scan complete flag
- `busy`  out  1  high in any state other than IDLE/DONE
- `point_idx`  out  CNT_W  index of current point (0-based)

## Operation
- Registers (write-only, reset 0): 0 start_lo, 1 start_hi, 2 step_lo, 3 step_hi, 4 npoints, 5 settle, 6 dwell, 7 ctrl (bit0 start, bit1 abort; self-clearing, not stored).
- Start: accepted only in IDLE or DONE with npoints != 0; latches start, step, npoints, settle, dwell into working copies; `ftw`<=start, `point_idx`<=0, `scanover`<=0. Start with npoints == 0: no state change, `scanover`<=1. Start while `busy`: ignored.
- Register writes during a scan update the programmable registers only; the running scan uses the latched copies.
- Abort (any state): next state IDLE, `sw_acq`<=0, `scanover`<=0, `point_idx` held. Start and abort in the same write: abort wins.
- FSM states: IDLE, LOAD, WAIT_DDS, SETTLE, ACQ, NEXT, DONE.
  - IDLE -> LOAD on accepted start.
  - LOAD: `dds_load`=1 for exactly this cycle; -> WAIT_DDS.
  - WAIT_DDS: hold until `dds_done`=1; -> SETTLE. `dds_done` in any other state ignored.
  - SETTLE: stay max(settle,1) cycles; -> ACQ.
  - ACQ: `sw_acq`=1 for max(dwell,1) cycles; -> NEXT.
  - NEXT: if `point_idx`+1 == npoints -> DONE with `scanover`<=1; else `point_idx`+=1, `ftw`<=`ftw`+step (mod 2^FTW_W, carry discarded), -> LOAD.
  - DONE: `scanover` held 1 until next accepted start or abort.
- Outputs are registered; `dds_load` and `sw_acq` decode directly from registered state.

## Timing
- Reset values: `ftw`=0, `dds_load`=0, `sw_acq`=0, `scanover`=0, `busy`=0, `point_idx`=0, state IDLE.
- Start write sampled on edge k -> state LOAD, `dds_load`=1, `busy`=1 in cycle k+1.
- `dds_done` sampled on edge j -> SETTLE from cycle j+1; `sw_acq` rises at cycle j+1+max(settle,1), stays high max(dwell,1) cycles.
- Per point, after `dds_done`: max(settle,1)+max(dwell,1)+1 (NEXT) cycles before next `dds_load` (+1 LOAD cycle, +loader latency).
- `scanover` rises the cycle after the last NEXT; `busy` falls the same cycle.
- Reset asserted mid-scan: all outputs to reset values immediately (asynchronous); no `dds_load` pulse may be issued on release.

## Test plan
- Basic scan: start=0x0000_1000, step=0x0000_0100, npoints=3, settle=4, dwell=8, loader answers `dds_done` 5 cycles after each `dds_load` -> three `dds_load` pulses with `ftw` 0x1000, 0x1100, 0x1200; three `sw_acq` pulses of 8 cycles each starting 4 cycles after each `dds_done`; `scanover`=1 after third.
- Wrap: start=0xFFFF_FF80, step=0x100, npoints=2 -> second `ftw`=0x0000_0080.
- Zero values: settle=0, dwell=0, npoints=1 -> one `dds_load`, `sw_acq` high 1 cycle, 1 cycle after `dds_done`; npoints=0 start -> no `dds_load`, `scanover`=1 next cycle.
- Abort during ACQ of point 1 -> `sw_acq` low next cycle, state IDLE, `busy`=0, `scanover`=0, no further `dds_load`; restart succeeds from point 0.
- Rewrite step=0x200 mid-scan and issue start while busy -> current scan unaffected and not restarted; next scan uses 0x200.
- Assert `NSYSRESET` while in WAIT_DDS, then release and pulse `dds_done` -> all outputs 0, stays IDLE, no `dds_load`.
